// File: rtl/cam_video_timing_if.sv
// cam_video_timing_if: camera byte bus in (master drives), assembled pixel and timing status out (slave drives)
interface cam_video_timing_if;
  logic [7:0] din;
  logic href, vsync;
  logic [15:0] pixel;
  logic pixel_valid, active_video, hblank, hsync, vblank, frame_done, frame_err;
  logic [9:0] line_count;
  modport master (
    output din, href, vsync,
    input pixel, pixel_valid, active_video, hblank, hsync, vblank, frame_done, line_count, frame_err
  );
  modport slave (
    input din, href, vsync,
    output pixel, pixel_valid, active_video, hblank, hsync, vblank, frame_done, line_count, frame_err
  );
endinterface

// File: rtl/cam_video_timing.sv
// cam_video_timing: pairs camera bytes into 16-bit pixels and tracks line/frame timing with a sticky error flag (ports: clk, reset active-low async, bus slave)
module cam_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input logic clk,
  input logic reset,
  cam_video_timing_if.slave bus
);
  typedef enum logic [1:0] {WAIT_FRAME, VBLANK, LINE, HBLANK} state_t;
  localparam logic [10:0] H_PIX = 11'(H_ACTIVE);
  localparam logic [9:0] V_LINES = 10'(V_ACTIVE);
  state_t state, nxt;
  logic [7:0] din_r, hi;
  logic href_r, href_p, vsync_r, vsync_p, phase;
  logic href_rise, href_fall, vsync_rise, vsync_fall, cap, line_end, frame_end;
  logic [10:0] pix_cnt;
  logic [9:0] line_inc;
  assign href_rise = href_r & ~href_p;
  assign href_fall = ~href_r & href_p;
  assign vsync_rise = vsync_r & ~vsync_p;
  assign vsync_fall = ~vsync_r & vsync_p;
  assign line_inc = &bus.line_count ? bus.line_count : bus.line_count + 10'd1;
  assign bus.active_video = state == LINE;
  assign bus.hblank = state == HBLANK;
  assign bus.vblank = state == WAIT_FRAME || state == VBLANK;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= WAIT_FRAME;
    else state <= nxt;
  // the byte on the href rising edge belongs to the new line, so capture follows the next state
  always_comb begin
    nxt = state;
    case (state)
      WAIT_FRAME: nxt = vsync_fall ? VBLANK : WAIT_FRAME;
      VBLANK:     nxt = href_rise ? LINE : VBLANK;
      LINE:       nxt = vsync_rise ? VBLANK : href_fall ? HBLANK : LINE;
      HBLANK:     nxt = vsync_rise ? VBLANK : href_rise ? LINE : HBLANK;
      default:    nxt = WAIT_FRAME;
    endcase
    cap = href_r && nxt == LINE;
    line_end = state == LINE && (href_fall || vsync_rise);
    frame_end = (state == LINE || state == HBLANK) && vsync_rise;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      din_r <= '0; hi <= '0; phase <= 1'b0; pix_cnt <= '0;
      href_r <= 1'b0; href_p <= 1'b0; vsync_r <= 1'b0; vsync_p <= 1'b0;
      bus.pixel <= '0; bus.pixel_valid <= 1'b0; bus.hsync <= 1'b0; bus.frame_done <= 1'b0;
      bus.line_count <= '0; bus.frame_err <= 1'b0;
    end else begin
      din_r <= bus.din; href_r <= bus.href; href_p <= href_r;
      vsync_r <= bus.vsync; vsync_p <= vsync_r;
      phase <= cap && !phase;
      if (cap && !phase) hi <= din_r;
      if (cap && phase) bus.pixel <= {hi, din_r};
      bus.pixel_valid <= cap && phase;
      pix_cnt <= cap && state != LINE ? '0 : cap && phase && !(&pix_cnt) ? pix_cnt + 11'd1 : pix_cnt;
      bus.hsync <= line_end;
      bus.frame_done <= frame_end;
      bus.line_count <= bus.frame_done ? '0 : line_end ? line_inc : bus.line_count;
      // a frame closing on the same cycle as its last line counts that line
      bus.frame_err <= bus.frame_err || (line_end && (pix_cnt != H_PIX || phase))
        || (frame_end && (line_end ? line_inc : bus.line_count) != V_LINES)
        || (state == VBLANK && vsync_rise);
    end
endmodule

// File: tb/tb_cam_video_timing.sv
// tb_cam_video_timing: directed stimulus against a line/frame-level behavioural model plus literal spot checks
module tb_cam_video_timing;
  localparam int H = 4;
  localparam int V = 3;
  typedef struct packed {
    logic [15:0] pixel;
    logic pv, av, hb, hs, vb, fd;
    logic [9:0] lc;
    logic fe;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  cam_video_timing_if bus ();
  cam_video_timing #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, passed = 0, pv_cnt = 0, hs_cnt = 0, fd_cnt = 0, cyc = 0;
  int drv_cyc, c1, c2, p0, h0, f0;
  logic both_seen = 1'b0, ab_watch = 1'b0, ab_seen = 1'b0;
  logic [15:0] seen_px[$];
  int seen_cyc[$];
  exp_t cur, nxt_e;
  logic armed, in_line, clr, err, closed, e_pv, e_hs, e_fd, phs, pvs, h, v;
  logic [7:0] b;
  logic [15:0] mpix;
  int started, lines;
  logic [7:0] q[$];
  function automatic exp_t rst_exp();
    exp_t e;
    e = '0;
    e.vb = 1'b1;
    return e;
  endfunction
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  task automatic chk_i(input string n, input int a, input int e);
    checks++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask
  task automatic close_line();
    e_hs = 1'b1;
    if (q.size() != 2 * H) err = 1'b1;
    if (lines < 1023) lines++;
    in_line = 1'b0;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (!reset) begin
      armed = 0; in_line = 0; clr = 0; err = 0; started = 0; lines = 0;
      mpix = '0; phs = 0; pvs = 0; q.delete();
      cur = rst_exp(); nxt_e = rst_exp();
    end else begin
      cur = nxt_e;
      h = bus.href; v = bus.vsync; b = bus.din;
      e_pv = 0; e_hs = 0; e_fd = 0; closed = 0;
      if (clr) begin lines = 0; clr = 0; end
      if (armed && v && !pvs) begin
        if (in_line) close_line();
        if (started > 0) begin
          e_fd = 1; if (lines != V) err = 1;
          started = 0; clr = 1; closed = 1;
        end else err = 1;
      end
      if (armed && in_line && !h && phs) close_line();
      if (armed && !in_line && !closed && h && !phs) begin
        in_line = 1; started++; q.delete();
      end
      if (in_line && h) begin
        q.push_back(b);
        if (q.size() % 2 == 0) begin mpix = {q[q.size() - 2], q[q.size() - 1]}; e_pv = 1; end
      end
      if (!armed && !v && pvs) armed = 1;
      nxt_e.pixel = mpix; nxt_e.pv = e_pv; nxt_e.av = in_line;
      nxt_e.hb = armed && !in_line && started > 0; nxt_e.hs = e_hs;
      nxt_e.vb = !armed || (!in_line && started == 0); nxt_e.fd = e_fd;
      nxt_e.lc = 10'(lines); nxt_e.fe = err;
      phs = h; pvs = v;
    end
  end
  always @(negedge clk) begin
    chk("pixel", bus.pixel, cur.pixel);
    chk("pixel_valid", 16'(bus.pixel_valid), 16'(cur.pv));
    chk("active_video", 16'(bus.active_video), 16'(cur.av));
    chk("hblank", 16'(bus.hblank), 16'(cur.hb));
    chk("hsync", 16'(bus.hsync), 16'(cur.hs));
    chk("vblank", 16'(bus.vblank), 16'(cur.vb));
    chk("frame_done", 16'(bus.frame_done), 16'(cur.fd));
    chk("line_count", 16'(bus.line_count), 16'(cur.lc));
    chk("frame_err", 16'(bus.frame_err), 16'(cur.fe));
    if (bus.pixel_valid) begin pv_cnt++; seen_px.push_back(bus.pixel); seen_cyc.push_back(cyc); end
    if (bus.hsync) hs_cnt++;
    if (bus.frame_done) fd_cnt++;
    if (bus.hsync && bus.frame_done) both_seen = 1'b1;
    if (ab_watch && (bus.pixel[15:8] == 8'hAB || bus.pixel[7:0] == 8'hAB)) ab_seen = 1'b1;
  end
  task automatic step(input logic sh, input logic sv, input logic [7:0] d);
    @(negedge clk);
    bus.href = sh; bus.vsync = sv; bus.din = d; drv_cyc = cyc;
  endtask
  task automatic gap(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask
  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'(base + 8'(i)));
    gap(5);
  endtask
  task automatic vsync_pulse();
    repeat (3) step(1'b0, 1'b1, 8'h00);
    gap(5);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0; bus.href = 1'b0; bus.vsync = 1'b0; bus.din = 8'h00;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
  endtask
  initial begin
    bus.din = 8'h00; bus.href = 1'b0; bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vblank", 16'(bus.vblank), 16'd1);
    chk("rst_line_count", 16'(bus.line_count), 16'd0);
    #1 reset = 1'b1;
    send_line(8, 8'h40);
    send_line(8, 8'h50);
    chk_i("wait_pixel_valid", pv_cnt, 0);
    chk_i("wait_hsync", hs_cnt, 0);
    vsync_pulse();
    seen_px.delete(); seen_cyc.delete(); h0 = hs_cnt;
    step(1'b1, 1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h34); c1 = drv_cyc;
    step(1'b1, 1'b0, 8'h56);
    step(1'b1, 1'b0, 8'h78); c2 = drv_cyc;
    gap(5);
    chk_i("l1_pixel_count", seen_px.size(), 2);
    if (seen_px.size() == 2) begin
      chk("l1_px0", seen_px[0], 16'h1234);
      chk("l1_px1", seen_px[1], 16'h5678);
      chk_i("l1_lat0", seen_cyc[0] - c1, 2);
      chk_i("l1_lat1", seen_cyc[1] - c2, 2);
    end
    chk_i("l1_hsync", hs_cnt - h0, 1);
    chk("l1_line_count", 16'(bus.line_count), 16'd1);
    do_reset();
    vsync_pulse();
    h0 = hs_cnt; f0 = fd_cnt;
    repeat (V) send_line(2 * H, 8'h01);
    vsync_pulse();
    chk_i("frame_hsync", hs_cnt - h0, V);
    chk_i("frame_done", fd_cnt - f0, 1);
    chk("frame_err_clean", 16'(bus.frame_err), 16'd0);
    chk("frame_line_count", 16'(bus.line_count), 16'd0);
    send_line(2 * H - 1, 8'h20);
    chk("odd_line_err", 16'(bus.frame_err), 16'd1);
    repeat (V - 1) send_line(2 * H, 8'h30);
    vsync_pulse();
    repeat (V) send_line(2 * H, 8'h38);
    vsync_pulse();
    chk("err_sticky", 16'(bus.frame_err), 16'd1);
    do_reset();
    vsync_pulse();
    h0 = hs_cnt; f0 = fd_cnt;
    repeat (V - 2) send_line(2 * H, 8'h70);
    for (int i = 0; i < 2 * H; i++) step(1'b1, 1'b0, 8'(8'h80 + 8'(i)));
    repeat (3) step(1'b0, 1'b1, 8'h00);
    gap(5);
    chk_i("short_hsync", hs_cnt - h0, V - 1);
    chk_i("short_frame_done", fd_cnt - f0, 1);
    chk("short_same_cycle", 16'(both_seen), 16'd1);
    chk("short_err", 16'(bus.frame_err), 16'd1);
    do_reset();
    vsync_pulse();
    p0 = pv_cnt;
    step(1'b1, 1'b0, 8'hAB);
    @(negedge clk);
    #1 reset = 1'b0; ab_watch = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_pixel", bus.pixel, 16'h0000);
    chk("mid_rst_active", 16'(bus.active_video), 16'd0);
    chk("mid_rst_err", 16'(bus.frame_err), 16'd0);
    #1 reset = 1'b1;
    step(1'b1, 1'b0, 8'hCD);
    step(1'b1, 1'b0, 8'hEF);
    gap(5);
    chk_i("mid_rst_no_pixel", pv_cnt - p0, 0);
    vsync_pulse();
    send_line(2 * H, 8'h60);
    chk_i("after_rst_pixels", pv_cnt - p0, H);
    chk("no_stale_byte", 16'(ab_seen), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
